// File: rtl/commit_trace_buf_pkg.sv
// Shared widths and packet layout for the commit trace buffer.
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN (adds per-entry cycle timestamp).
package commit_trace_buf_pkg;

  // Field widths mirror the core's RegBus / InstBus / RegAddrBus buses.
  localparam int unsigned REG_W      = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Saturating drop counter and optional timestamp widths.
  localparam int unsigned DROP_W = 16;
  localparam int unsigned TIME_W = 32;

  // One retired instruction as captured from the writeback stage.
  typedef struct packed {
    logic [REG_W-1:0]      pc;
    logic [INST_W-1:0]     instr;
    logic                  wreg;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_W-1:0]      wdata;
  } commit_pkt_t;

  localparam int unsigned PKT_W = $bits(commit_pkt_t);

  // Register writes to r0 are architecturally void and are not reported.
  function automatic logic report_wreg(input logic wreg, input logic [REG_ADDR_W-1:0] waddr);
    return wreg & (waddr != '0);
  endfunction

endpackage

// File: rtl/commit_trace_buf_if.sv
// Trace sink bus: first-word fall-through head packet with valid/ready.
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN (adds trace_time_o).
interface commit_trace_buf_if
  import commit_trace_buf_pkg::*;
#(
  parameter int unsigned SEQ_W = 16
);

  logic                  trace_valid_o;
  logic                  trace_ready_i;
  logic [REG_W-1:0]      trace_pc_o;
  logic [INST_W-1:0]     trace_instr_o;
  logic                  trace_wreg_o;
  logic [REG_ADDR_W-1:0] trace_waddr_o;
  logic [REG_W-1:0]      trace_wdata_o;
  logic [SEQ_W-1:0]      trace_seq_o;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TIME_W-1:0]     trace_time_o;
`endif

  // Producer side (the trace buffer).
  modport master (
    output trace_valid_o,
    input  trace_ready_i,
    output trace_pc_o,
    output trace_instr_o,
    output trace_wreg_o,
    output trace_waddr_o,
    output trace_wdata_o,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    output trace_time_o,
`endif
    output trace_seq_o
  );

  // Consumer side (trace / difftest sink).
  modport slave (
    input  trace_valid_o,
    output trace_ready_i,
    input  trace_pc_o,
    input  trace_instr_o,
    input  trace_wreg_o,
    input  trace_waddr_o,
    input  trace_wdata_o,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    input  trace_time_o,
`endif
    input  trace_seq_o
  );

endinterface

// File: rtl/commit_trace_fifo.sv
// Generic first-word fall-through FIFO with AW+1 bit pointers and registered
// occupancy/full flags. Read data is forced to zero while empty.
module commit_trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop_req,
  output logic [DATA_W-1:0] rdata,
  output logic              pop_ok,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_n;
  logic [PW-1:0]     rd_ptr_n;
  logic              push_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  // Handshake qualification: a pop frees a slot for a same-cycle push at full.
  assign empty   = (count == '0);
  assign pop_ok  = pop_req & ~empty;
  assign push_ok = push_req & (~full | pop_ok);

  // Next pointer values.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (push_ok) wr_ptr_n = wr_ptr + PW'(1);
    if (pop_ok)  rd_ptr_n = rd_ptr + PW'(1);
  end

  // Pointer, occupancy and full registers move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= wr_ptr_n - rd_ptr_n;
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    end
  end

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Fall-through head read, zeroed while empty.
  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/commit_trace_buf.sv
// Commit trace buffer: captures every retired instruction from the core's
// writeback stream into a FIFO and presents it to a trace sink. The core is
// never stalled; commits arriving while full are dropped and counted, and the
// per-commit sequence number exposes the gap.
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN (cycle timestamp per entry).
module commit_trace_buf
  import commit_trace_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned SEQ_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid_i,
  input  logic [REG_W-1:0]      commit_pc_i,
  input  logic [INST_W-1:0]     commit_instr_i,
  input  logic                  commit_wreg_i,
  input  logic [REG_ADDR_W-1:0] commit_waddr_i,
  input  logic [REG_W-1:0]      commit_wdata_i,
  output logic [AW:0]           count_o,
  output logic                  full_o,
  output logic [DROP_W-1:0]     drop_cnt_o,
  commit_trace_buf_if.master    trace
);

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  localparam int unsigned PAYLOAD_W = SEQ_W + TIME_W + PKT_W;
`else
  localparam int unsigned PAYLOAD_W = SEQ_W + PKT_W;
`endif

  logic [SEQ_W-1:0]     seq_q;
  logic                 fifo_empty;
  logic                 pop_ok;
  logic                 drop;
  commit_pkt_t          wr_pkt;
  commit_pkt_t          rd_pkt;
  logic [PAYLOAD_W-1:0] wr_payload;
  logic [PAYLOAD_W-1:0] rd_payload;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TIME_W-1:0]    time_q;
`endif

  // Assemble the stored packet from the commit stream.
  always_comb begin
    wr_pkt       = '0;
    wr_pkt.pc    = commit_pc_i;
    wr_pkt.instr = commit_instr_i;
    wr_pkt.wreg  = commit_wreg_i;
    wr_pkt.waddr = commit_waddr_i;
    wr_pkt.wdata = commit_wdata_i;
  end

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  assign wr_payload = {seq_q, time_q, wr_pkt};
`else
  assign wr_payload = {seq_q, wr_pkt};
`endif

  commit_trace_fifo #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DATA_W (PAYLOAD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (commit_valid_i),
    .wdata    (wr_payload),
    .pop_req  (trace.trace_ready_i),
    .rdata    (rd_payload),
    .pop_ok   (pop_ok),
    .empty    (fifo_empty),
    .full     (full_o),
    .count    (count_o)
  );

  // A commit is lost only when full and the sink is not freeing a slot.
  assign drop = commit_valid_i & full_o & ~pop_ok;

  // Sequence number advances on every commit, kept or dropped.
  always_ff @(posedge clk) begin
    if (rst)                 seq_q <= '0;
    else if (commit_valid_i) seq_q <= seq_q + SEQ_W'(1);
  end

  // Saturating count of dropped commits.
  always_ff @(posedge clk) begin
    if (rst)                           drop_cnt_o <= '0;
    else if (drop && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
  end

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  // Free-running cycle counter sampled into each pushed entry.
  always_ff @(posedge clk) begin
    if (rst) time_q <= '0;
    else     time_q <= time_q + TIME_W'(1);
  end
`endif

  // Unpack the fall-through head entry onto the trace bus.
  assign rd_pkt              = rd_payload[PKT_W-1:0];
  assign trace.trace_valid_o = ~fifo_empty;
  assign trace.trace_pc_o    = rd_pkt.pc;
  assign trace.trace_instr_o = rd_pkt.instr;
  assign trace.trace_wreg_o  = report_wreg(rd_pkt.wreg, rd_pkt.waddr);
  assign trace.trace_waddr_o = rd_pkt.waddr;
  assign trace.trace_wdata_o = rd_pkt.wdata;
  assign trace.trace_seq_o   = rd_payload[PAYLOAD_W-1 -: SEQ_W];
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  assign trace.trace_time_o  = rd_payload[PKT_W +: TIME_W];
`endif

endmodule
